// File: rtl/sync_gray_ptr.sv
`default_nettype none
// ============================================================================
// Module   : sync_gray_ptr
// Purpose  : Carries a gray-coded FIFO pointer into the destination clock
//            domain through a STAGES-deep flop chain, then produces the
//            registered binary pointer, an update pulse and the modular
//            increment since the previous update.
// Options  : SYNC_GRAY_PTR_CHK_EN - when defined, adds a sticky ptr_err flag
//            raised when an update advances by more than MAX_DELTA.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module sync_gray_ptr #(
  parameter int ASIZE     = 4,
  parameter int STAGES    = 2,
  parameter int MAX_DELTA = 1
) (
  input  logic             dst_clk,
  input  logic             dst_rst,
  input  logic [ASIZE:0]   src_gray,
  input  logic             err_clr,
  output logic [ASIZE:0]   sync_gray,
  output logic [ASIZE:0]   sync_bin,
  output logic             ptr_upd,
  output logic [ASIZE:0]   ptr_delta,
  output logic             ptr_err
);

  localparam int PW = ASIZE + 1;

  logic [PW-1:0] stage_q [STAGES];
  logic [PW-1:0] stage_d [STAGES];
  logic [PW-1:0] bin_conv;
  logic [PW-1:0] sync_bin_q, sync_bin_d;
  logic [PW-1:0] ptr_delta_q, ptr_delta_d;
  logic          ptr_upd_q, ptr_upd_d;

  // Synchroniser chain: pure flop-to-flop, src_gray enters unqualified.
  always_comb begin
    stage_d[0] = src_gray;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    bin_conv = '0;
    for (int i = 0; i < PW; i++) begin
      bin_conv[i] = ^(stage_q[STAGES-1] >> i);
    end
  end

  // Update stage: sync_bin doubles as the previous-binary reference, so the
  // delta is taken against it before it is overwritten; delta holds otherwise.
  always_comb begin
    sync_bin_d  = bin_conv;
    ptr_upd_d   = (bin_conv != sync_bin_q);
    ptr_delta_d = ptr_delta_q;
    if (ptr_upd_d) begin
      ptr_delta_d = bin_conv - sync_bin_q;
    end
  end

  // All destination-domain state; reset discards anything in flight.
  always_ff @(posedge dst_clk) begin
    if (dst_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
      sync_bin_q  <= '0;
      ptr_delta_q <= '0;
      ptr_upd_q   <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      sync_bin_q  <= sync_bin_d;
      ptr_delta_q <= ptr_delta_d;
      ptr_upd_q   <= ptr_upd_d;
    end
  end

`ifdef SYNC_GRAY_PTR_CHK_EN
  localparam logic [PW:0] MAX_D = (PW+1)'(MAX_DELTA);

  logic ptr_err_q, ptr_err_d;

  // Sticky step check: a new violation outranks a simultaneous clear.
  always_comb begin
    ptr_err_d = ptr_err_q;
    if (err_clr) begin
      ptr_err_d = 1'b0;
    end
    if (ptr_upd_d && ({1'b0, ptr_delta_d} > MAX_D)) begin
      ptr_err_d = 1'b1;
    end
  end

  // Error flag register, cleared by reset above everything else.
  always_ff @(posedge dst_clk) begin
    if (dst_rst) begin
      ptr_err_q <= 1'b0;
    end else begin
      ptr_err_q <= ptr_err_d;
    end
  end

  assign ptr_err = ptr_err_q;
`else
  // Check disabled: err_clr and MAX_DELTA are intentionally left without load.
  localparam int unused_max_delta = MAX_DELTA;
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ptr_err        = 1'b0;
`endif

  assign sync_gray = stage_q[STAGES-1];
  assign sync_bin  = sync_bin_q;
  assign ptr_upd   = ptr_upd_q;
  assign ptr_delta = ptr_delta_q;

endmodule
`default_nettype wire
